// File: rtl/load_align_unit.sv
// Load alignment path: issues aligned memory beats, merges split accesses, extracts and extends the load lane.
// Optional macro MISALIGNED_LOAD_EN enables two-beat split accesses; without it split loads return rsp_fault.
module load_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_func3,
    input  logic [4:0]        req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_fault
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
`ifdef MISALIGNED_LOAD_EN
        S_REQ1,
        S_WAIT1,
`endif
        S_RESP
    } state_t;

    // funct3 codes with no matching access size fall back to a full-width raw load
    function automatic logic is_unsupported(input logic [2:0] f3);
        return (f3 == 3'd7) || ((DATA_W == 32) && ((f3 == 3'd3) || (f3 == 3'd6)));
    endfunction

    function automatic logic [3:0] size_of(input logic [2:0] f3);
        logic [3:0] sz;
        if (is_unsupported(f3)) begin
            sz = 4'(BYTES);
        end else begin
            case (f3[1:0])
                2'd0:    sz = 4'd1;
                2'd1:    sz = 4'd2;
                2'd2:    sz = 4'd4;
                default: sz = 4'd8;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_split(input logic [OFF_W-1:0] off, input logic [2:0] f3);
        return (5'(off) + 5'(size_of(f3))) > 5'(BYTES);
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [2*DATA_W-1:0] pair,
                                                   input logic [OFF_W-1:0]   off,
                                                   input logic [2:0]         f3);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] res;
        logic [3:0]        sz;
        logic              fill;
        sh = DATA_W'(pair >> {off, 3'b000});
        sz = size_of(f3);
        case (sz)
            4'd1:    fill = sh[7];
            4'd2:    fill = sh[15];
            4'd4:    fill = sh[31];
            default: fill = sh[DATA_W-1];
        endcase
        fill = fill & ~f3[2] & ~is_unsupported(f3);
        res  = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            res[i] = (i < (32'(sz) << 3)) ? sh[i] : fill;
        end
        return res;
    endfunction

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [2:0]         func3_q, func3_d;
    logic [4:0]         rd_q, rd_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               fault_q, fault_d;
`ifdef MISALIGNED_LOAD_EN
    logic [DATA_W-1:0]  beat0_q, beat0_d;
`endif

    logic [OFF_W-1:0]   off_q;
    logic [ADDR_W-1:0]  base_q;

    assign off_q  = addr_q[OFF_W-1:0];
    assign base_q = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    assign rsp_data  = data_q;
    assign rsp_rd    = rd_q;
    assign rsp_fault = fault_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        func3_d       = func3_q;
        rd_d          = rd_q;
        data_d        = data_q;
        fault_d       = fault_q;
`ifdef MISALIGNED_LOAD_EN
        beat0_d       = beat0_q;
`endif
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        rsp_valid     = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    func3_d = req_func3;
                    rd_d    = req_rd;
                    fault_d = 1'b0;
                    state_d = S_REQ0;
`ifndef MISALIGNED_LOAD_EN
                    if (is_split(req_addr[OFF_W-1:0], req_func3)) begin
                        fault_d = 1'b1;
                        data_d  = '0;
                        state_d = S_RESP;
                    end
`endif
                end
            end
            S_REQ0: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = base_q;
                if (mem_req_ready) state_d = S_WAIT0;
            end
            S_WAIT0: begin
                if (mem_rsp_valid) begin
`ifdef MISALIGNED_LOAD_EN
                    if (is_split(off_q, func3_q)) begin
                        beat0_d = mem_rsp_data;
                        state_d = S_REQ1;
                    end else begin
                        data_d  = extract({{DATA_W{1'b0}}, mem_rsp_data}, off_q, func3_q);
                        state_d = S_RESP;
                    end
`else
                    data_d  = extract({{DATA_W{1'b0}}, mem_rsp_data}, off_q, func3_q);
                    state_d = S_RESP;
`endif
                end
            end
`ifdef MISALIGNED_LOAD_EN
            S_REQ1: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = base_q + ADDR_W'(BYTES);
                if (mem_req_ready) state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (mem_rsp_valid) begin
                    data_d  = extract({mem_rsp_data, beat0_q}, off_q, func3_q);
                    state_d = S_RESP;
                end
            end
`endif
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            func3_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
`ifdef MISALIGNED_LOAD_EN
            beat0_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            func3_q <= func3_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            fault_q <= fault_d;
`ifdef MISALIGNED_LOAD_EN
            beat0_q <= beat0_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Randomized self-checking bench for load_align_unit (DATA_W=32) against a byte-level reference model.
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_func3;
    logic [4:0]  req_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_fault;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MISALIGNED_LOAD_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    load_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_func3     (req_func3),
        .req_rd        (req_rd),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_rd        (rsp_rd),
        .rsp_fault     (rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: pick bytes out of a little-endian two-word window, then extend arithmetically.
    task automatic model(input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] b0, input logic [31:0] b1,
                         output logic [31:0] data, output logic fault, output int beats);
        byte unsigned win[8];
        int           off, size;
        bit           unsup, split, sext;
        longint unsigned val;
        off   = int'(addr % 4);
        unsup = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        size  = unsup ? 4 : (1 << f3[1:0]);
        sext  = !unsup && !f3[2];
        split = (off + size) > 4;
        for (int k = 0; k < 4; k++) begin
            win[k]     = byte'(b0 >> (8 * k));
            win[k + 4] = split ? byte'(b1 >> (8 * k)) : 8'h00;
        end
        if (split && !SPLIT_EN) begin
            data  = 32'h0;
            fault = 1'b1;
            beats = 0;
        end else begin
            val = 0;
            for (int k = 0; k < size; k++) val = val + (longint'(win[off + k]) << (8 * k));
            if (sext && val >= (64'd1 << (8 * size - 1))) val = val + (64'hFFFF_FFFF_FFFF_FFFF << (8 * size));
            data  = val[31:0];
            fault = 1'b0;
            beats = split ? 2 : 1;
        end
    endtask

    task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] b0, input logic [31:0] b1,
                            input int mem_stall, input int rsp_stall);
        logic [31:0] exp_data;
        logic        exp_fault;
        int          exp_beats, exp_lat;
        logic [31:0] base, beat_addr;
        int          cyc, issued, stall, rstall;
        bit          pending, seen, done;
        model(addr, f3, b0, b1, exp_data, exp_fault, exp_beats);
        base    = addr & 32'hFFFF_FFFC;
        exp_lat = exp_fault ? 1 : ((exp_beats == 2 ? 5 : 3) + mem_stall);

        @(negedge clk);
        req_addr  = addr;
        req_func3 = f3;
        req_rd    = rd;
        req_valid = 1'b1;
        check_eq("req_ready_idle", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;

        cyc = 0; issued = 0; stall = mem_stall; rstall = rsp_stall;
        pending = 0; seen = 0; done = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b0;
            rsp_ready     = 1'b0;
            if (pending) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = (issued == 1) ? b0 : b1;
                pending       = 0;
            end
            check_eq("req_ready_busy", req_ready, 0);
            if (mem_req_valid) begin
                beat_addr = (issued == 0) ? base : base + 32'd4;
                check_eq("mem_req_addr", mem_req_addr, beat_addr);
                if (stall > 0) stall--;
                else begin
                    mem_req_ready = 1'b1;
                    pending       = 1;
                    issued++;
                end
            end
            if (rsp_valid) begin
                if (!seen) begin
                    seen = 1;
                    check_eq("latency", cyc, exp_lat);
                end
                check_eq("rsp_data", rsp_data, exp_data);
                check_eq("rsp_rd", rsp_rd, rd);
                check_eq("rsp_fault", rsp_fault, exp_fault);
                if (rstall > 0) rstall--;
                else begin
                    rsp_ready = 1'b1;
                    done      = 1;
                end
            end
        end
        check_eq("completed", done, 1);
        @(posedge clk);
        #1;
        rsp_ready     = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        check_eq("beat_count", issued, exp_beats);
        @(negedge clk);
        check_eq("single_rsp", rsp_valid, 0);
        check_eq("req_ready_after", req_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 1);
        check_eq({tag, "_mem_req_valid"}, mem_req_valid, 0);
        check_eq({tag, "_mem_req_addr"}, mem_req_addr, 0);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_data"}, rsp_data, 0);
        check_eq({tag, "_rsp_rd"}, rsp_rd, 0);
        check_eq({tag, "_rsp_fault"}, rsp_fault, 0);
    endtask

    initial begin
        logic [2:0] f3_pool [8];
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_func3 = '0; req_rd = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_load(32'h0000_1003, 3'd0, 5'd1, 32'h80FF_1234, 32'h0, 0, 0);
        run_load(32'h0000_1002, 3'd5, 5'd2, 32'hBEEF_0000, 32'h0, 0, 0);
        run_load(32'h0000_1001, 3'd1, 5'd3, 32'h0080_0100, 32'h0, 0, 0);
        run_load(32'h0000_1003, 3'd2, 5'd4, 32'hDD00_0000, 32'h00CC_BBAA, 0, 0);
        run_load(32'h0000_1000, 3'd2, 5'd5, 32'h1234_5678, 32'h0, 3, 2);
        run_load(32'hFFFF_FFFE, 3'd2, 5'd6, 32'hA1B2_C3D4, 32'h5566_7788, 1, 1);
        run_load(32'h0000_2001, 3'd7, 5'd7, 32'h0102_0304, 32'h0506_0708, 0, 0);

        // Abort an access in WAIT0, then offer a stray response beat.
        @(negedge clk);
        req_addr = 32'h0000_3000; req_func3 = 3'd2; req_rd = 5'd9; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        check_reset_outputs("abort");
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check_reset_outputs("stray");
        run_load(32'h0000_3002, 3'd1, 5'd10, 32'h8765_4321, 32'h0, 0, 0);

        f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        for (int n = 0; n < 40; n++) begin
            run_load($urandom, f3_pool[$urandom_range(0, 7)], 5'($urandom_range(0, 31)),
                     $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
